y_mc_ctrl: RTL and testbench

- Multi-cycle control unit for the yIF/yID/yEX/yDM/yWB/yPC datapath.
- Replaces per-instruction control decoding in the lab bench with a registered FSM that sequences each instruction over 3–5 cycles.
- Supports data-memory wait states (ready handshake) and a bounded memory timeout.
- Takes interrupts at instruction boundaries and counts retired instructions.

---
 rtl/y_mc_pkg.sv | 39 +++
 rtl/y_mc_decode.sv | 43 ++++
 rtl/y_mc_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_y_mc_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y_mc_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
package y_mc_pkg;

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_I, C_LW, C_SW, C_BEQ, C_JAL, C_ILL
  } iclass_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_VEC    = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/y_mc_decode.sv
// Combinational opcode/funct3 classifier for the multi-cycle controller.
module y_mc_decode
  import y_mc_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output iclass_e    iclass,
  output logic [2:0] r_alu_op,
  output logic       r_funct_ok,
  output logic       illegal
);

  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OP_R:    iclass = C_R;
      OP_I:    iclass = C_I;
      OP_LW:   iclass = C_LW;
      OP_SW:   iclass = C_SW;
      OP_BEQ:  iclass = C_BEQ;
      OP_JAL:  iclass = C_JAL;
      default: begin
        iclass  = C_ILL;
        illegal = 1'b1;
      end
    endcase
  end

  // Only add/or/and are implemented; other funct3 values trap in EXEC.
  always_comb begin
    r_funct_ok = 1'b1;
    case (funct3)
      3'b000:  r_alu_op = ALU_ADD;
      3'b110:  r_alu_op = ALU_OR;
      3'b111:  r_alu_op = ALU_AND;
      default: begin
        r_alu_op   = ALU_AND;
        r_funct_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/y_mc_ctrl.sv
// Multi-cycle control FSM: sequences each instruction over 3-5 cycles,
// handles data-memory wait states with a timeout, interrupts and retire count.
//
// state  | meaning
// BOOT   | load PC with reset vector
// FETCH  | load IR, or take a pending interrupt vector
// DECODE | register read, opcode legality check
// EXEC   | ALU operation; BEQ resolves and retires here
// MEM    | data access, held until dmem_ready or timeout
// WB     | register write and PC update, retires
// TRAP   | illegal opcode / memory timeout, jump to entry_point
module y_mc_ctrl
  import y_mc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = 'h28,
  parameter int              MEM_TIMEOUT = 15,
  parameter int              CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ins,
  input  logic             zero,
  input  logic             int_req,
  input  logic [XLEN-1:0]  entry_point,
  input  logic             dmem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic [XLEN-1:0]  vec_addr,
  output logic             reg_write,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  iclass_e    iclass;
  logic [2:0] r_alu_op;
  logic       r_funct_ok;
  logic       illegal;
  logic       retire;
  logic       unused_ins;

  assign unused_ins = ^{ins[31:15], ins[11:7]};

  y_mc_decode u_decode (
    .opcode     (ins[6:0]),
    .funct3     (ins[14:12]),
    .iclass     (iclass),
    .r_alu_op   (r_alu_op),
    .r_funct_ok (r_funct_ok),
    .illegal    (illegal)
  );

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = PC_PLUS4;
    vec_addr  = '0;
    reg_write = 1'b0;
    alu_src   = 1'b0;
    alu_op    = ALU_AND;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    wb_sel    = WB_ALU;
    trap      = 1'b0;

    case (state_q)
      S_BOOT: begin
        pc_write = 1'b1;
        pc_sel   = PC_VEC;
        vec_addr = RESET_VEC;
        state_d  = S_FETCH;
      end
      S_FETCH: begin
        if (int_req) begin
          pc_write = 1'b1;
          pc_sel   = PC_VEC;
          vec_addr = entry_point;
        end else begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: state_d = illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (iclass)
          C_R: begin
            alu_src = 1'b0;
            if (r_funct_ok) begin
              alu_op  = r_alu_op;
              state_d = S_WB;
            end else begin
              state_d = S_TRAP;
            end
          end
          C_I: begin
            alu_src = 1'b1;
            alu_op  = ALU_ADD;
            state_d = S_WB;
          end
          C_LW, C_SW: begin
            alu_src = 1'b1;
            alu_op  = ALU_ADD;
            state_d = S_MEM;
          end
          C_BEQ: begin
            alu_src  = 1'b0;
            alu_op   = ALU_SUB;
            pc_write = 1'b1;
            pc_sel   = zero ? PC_BRANCH : PC_PLUS4;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          C_JAL:   state_d = S_WB;
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_read  = (iclass == C_LW);
        mem_write = (iclass == C_SW);
        if (dmem_ready) begin
          if (iclass == C_SW) begin
            pc_write = 1'b1;
            pc_sel   = PC_PLUS4;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
        case (iclass)
          C_LW:    wb_sel = WB_MEM;
          C_JAL: begin
            wb_sel = WB_PC4;
            pc_sel = PC_JUMP;
          end
          default: wb_sel = WB_ALU;
        endcase
      end
      S_TRAP: begin
        trap     = 1'b1;
        pc_write = 1'b1;
        pc_sel   = PC_VEC;
        vec_addr = entry_point;
        state_d  = S_FETCH;
      end
      default: state_d = S_BOOT;
    endcase

    if (rst) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      trap      = 1'b0;
      retire    = 1'b0;
      state_d   = S_BOOT;
    end
  end

  // Held at zero outside MEM so every entry into MEM starts a fresh count.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q != S_MEM) begin
      tmo_d = '0;
    end else if (!dmem_ready) begin
      tmo_d = tmo_q + 8'd1;
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (retire) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_BOOT;
      tmo_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_y_mc_ctrl.sv
// Self-checking bench for y_mc_ctrl: instruction-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_y_mc_ctrl;

  localparam int          MEM_TIMEOUT = 15;
  localparam logic [31:0] ENTRY       = 32'h100;

  localparam logic [31:0] I_ADD  = 32'h0020_8033;
  localparam logic [31:0] I_LW   = 32'h0000_A183;
  localparam logic [31:0] I_SW   = 32'h0020_A023;
  localparam logic [31:0] I_BEQ  = 32'h0000_0063;
  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_ADDI = 32'h0010_8093;
  localparam logic [31:0] I_BAD  = 32'h0000_007F;
  localparam logic [31:0] I_RBAD = 32'h0020_9033;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_JAL = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ins = I_ADD;
  logic        zero = 1'b0;
  logic        int_req = 1'b0;
  logic [31:0] entry_point = ENTRY;
  logic        dmem_ready = 1'b0;

  logic        ir_write, pc_write, reg_write, alu_src, mem_read, mem_write, trap;
  logic [1:0]  pc_sel, wb_sel;
  logic [31:0] vec_addr, retired;
  logic [2:0]  alu_op, state;

  logic        s_irw, s_pcw, s_rw, s_src, s_mr, s_mw, s_trap;
  logic [1:0]  s_psel, s_wbs;
  logic [31:0] s_vec;
  logic [2:0]  s_alu, s_state, s_retired;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  y_mc_ctrl u_dut (
    .clk(clk), .rst(rst), .ins(ins), .zero(zero), .int_req(int_req),
    .entry_point(entry_point), .dmem_ready(dmem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel), .vec_addr(vec_addr),
    .reg_write(reg_write), .alu_src(alu_src), .alu_op(alu_op), .mem_read(mem_read),
    .mem_write(mem_write), .wb_sel(wb_sel), .trap(trap), .retired(retired), .state(state)
  );

  // Narrow counter instance to exercise wrap-around in a short run.
  y_mc_ctrl #(.CNT_W(3)) u_small (
    .clk(clk), .rst(rst), .ins(ins), .zero(zero), .int_req(int_req),
    .entry_point(entry_point), .dmem_ready(dmem_ready),
    .ir_write(s_irw), .pc_write(s_pcw), .pc_sel(s_psel), .vec_addr(s_vec),
    .reg_write(s_rw), .alu_src(s_src), .alu_op(s_alu), .mem_read(s_mr),
    .mem_write(s_mw), .wb_sel(s_wbs), .trap(s_trap), .retired(s_retired), .state(s_state)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int kind_of(input logic [31:0] i);
    case (i[6:0])
      7'h33:   return K_R;
      7'h13:   return K_I;
      7'h03:   return K_LW;
      7'h23:   return K_SW;
      7'h63:   return K_BEQ;
      7'h6F:   return K_JAL;
      default: return -1;
    endcase
  endfunction

  function automatic int r_op(input logic [2:0] f3);
    case (f3)
      3'd0:    return 2;
      3'd6:    return 1;
      3'd7:    return 0;
      default: return -1;
    endcase
  endfunction

  // Model: position within the current instruction (step 0 fetch, 1 decode,
  // 2 execute, 3+ memory/writeback) plus boot/trap/memory flags.
  bit          m_boot = 1'b1, m_trap = 1'b0, m_mem = 1'b0;
  int          m_k = 0, m_wait = 0;
  logic [31:0] m_ret = '0;

  int          kd;
  logic [2:0]  e_st, e_alu;
  logic        e_irw, e_pcw, e_rw, e_mr, e_mw, e_trap, e_src;
  logic [1:0]  e_psel, e_wbs;
  logic [31:0] e_vec;
  bit          c_alu, c_src, c_wbs, ret_now;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_strobes", 64'({ir_write, pc_write, reg_write, mem_read, mem_write, trap}), 64'd0);
      chk("rst_strobes_w3", 64'({s_irw, s_pcw, s_rw, s_mr, s_mw, s_trap}), 64'd0);
      m_boot = 1'b1; m_trap = 1'b0; m_mem = 1'b0; m_k = 0; m_wait = 0; m_ret = '0;
    end else begin
      kd = kind_of(ins);
      e_st = 3'd0; e_alu = 3'd0; e_irw = 0; e_pcw = 0; e_rw = 0; e_mr = 0; e_mw = 0;
      e_trap = 0; e_src = 0; e_psel = 2'd0; e_wbs = 2'd0; e_vec = '0;
      c_alu = 0; c_src = 0; c_wbs = 0; ret_now = 0;
      if (m_boot) begin
        e_st = 3'd0; e_pcw = 1; e_psel = 2'd3; e_vec = 32'h28;
        m_boot = 1'b0; m_k = 0;
      end else if (m_trap) begin
        e_st = 3'd6; e_trap = 1; e_pcw = 1; e_psel = 2'd3; e_vec = entry_point;
        m_trap = 1'b0; m_k = 0;
      end else if (m_k == 0) begin
        e_st = 3'd1;
        if (int_req) begin
          e_pcw = 1; e_psel = 2'd3; e_vec = entry_point;
        end else begin
          e_irw = 1; m_k = 1;
        end
      end else if (m_k == 1) begin
        e_st = 3'd2;
        if (kd < 0) begin m_trap = 1'b1; m_k = 0; end
        else m_k = 2;
      end else if (m_k == 2) begin
        e_st = 3'd3; m_k = 3;
        case (kd)
          K_R: begin
            c_src = 1; e_src = 0;
            if (r_op(ins[14:12]) < 0) begin m_trap = 1'b1; m_k = 0; end
            else begin c_alu = 1; e_alu = 3'(r_op(ins[14:12])); end
          end
          K_I: begin c_src = 1; e_src = 1; c_alu = 1; e_alu = 3'd2; end
          K_LW, K_SW: begin
            c_src = 1; e_src = 1; c_alu = 1; e_alu = 3'd2; m_mem = 1'b1; m_wait = 0;
          end
          K_BEQ: begin
            c_src = 1; e_src = 0; c_alu = 1; e_alu = 3'd6;
            e_pcw = 1; e_psel = zero ? 2'd1 : 2'd0; ret_now = 1; m_k = 0;
          end
          default: ;
        endcase
      end else if (m_mem) begin
        e_st = 3'd4; e_mr = (kd == K_LW); e_mw = (kd == K_SW);
        if (dmem_ready) begin
          m_mem = 1'b0;
          if (kd == K_SW) begin e_pcw = 1; e_psel = 2'd0; ret_now = 1; m_k = 0; end
        end else begin
          m_wait++;
          if (m_wait == MEM_TIMEOUT) begin m_mem = 1'b0; m_trap = 1'b1; m_k = 0; end
        end
      end else begin
        e_st = 3'd5; e_rw = 1; e_pcw = 1; c_wbs = 1; ret_now = 1; m_k = 0;
        if (kd == K_LW) e_wbs = 2'd1;
        else if (kd == K_JAL) begin e_wbs = 2'd2; e_psel = 2'd2; end
      end

      chk("state", 64'(state), 64'(e_st));
      chk("ir_write", 64'(ir_write), 64'(e_irw));
      chk("pc_write", 64'(pc_write), 64'(e_pcw));
      chk("reg_write", 64'(reg_write), 64'(e_rw));
      chk("mem_read", 64'(mem_read), 64'(e_mr));
      chk("mem_write", 64'(mem_write), 64'(e_mw));
      chk("trap", 64'(trap), 64'(e_trap));
      chk("retired", 64'(retired), 64'(m_ret));
      chk("state_w3", 64'(s_state), 64'(e_st));
      chk("strobes_w3", 64'({s_irw, s_pcw, s_rw, s_mr, s_mw, s_trap}),
          64'({e_irw, e_pcw, e_rw, e_mr, e_mw, e_trap}));
      chk("retired_w3", 64'(s_retired), 64'(m_ret[2:0]));
      if (e_pcw) begin
        chk("pc_sel", 64'(pc_sel), 64'(e_psel));
        chk("pc_sel_w3", 64'(s_psel), 64'(e_psel));
      end
      if (e_pcw && e_psel == 2'd3) chk("vec_addr", 64'(vec_addr), 64'(e_vec));
      if (c_alu) chk("alu_op", 64'(alu_op), 64'(e_alu));
      if (c_src) chk("alu_src", 64'(alu_src), 64'(e_src));
      if (c_wbs) chk("wb_sel", 64'(wb_sel), 64'(e_wbs));
      if (ret_now) m_ret = m_ret + 32'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting in FETCH until the FSM is back in FETCH.
  task automatic run_instr(input logic [31:0] i, input int ready_at,
                           output int lat, output int n_mem, output int mr, output int mw,
                           output int rw, output int tr, output logic [1:0] ex_psel,
                           output logic [1:0] wbs, output logic [31:0] tvec);
    int mc;
    bit done;
    ins = i; lat = 0; n_mem = 0; mr = 0; mw = 0; rw = 0; tr = 0;
    ex_psel = 2'bxx; wbs = 2'bxx; tvec = '0; mc = 0; done = 0;
    while (!done && lat < 60) begin
      if (state == 3'd4) begin
        mc++;
        dmem_ready = (ready_at != 0 && mc == ready_at);
      end else begin
        dmem_ready = 1'b0;
      end
      #1;
      if (state == 3'd4) n_mem++;
      if (mem_read) mr++;
      if (mem_write) mw++;
      if (reg_write) rw++;
      if (state == 3'd3) ex_psel = pc_sel;
      if (state == 3'd5) wbs = wb_sel;
      if (trap) begin tr++; tvec = vec_addr; end
      lat++;
      tick();
      if (state == 3'd1) done = 1;
    end
    dmem_ready = 1'b0;
    chk("instr_budget", 64'(done), 64'd1);
  endtask

  int lat, n_mem, mr, mw, rw, tr;
  logic [1:0]  ex_psel, wbs;
  logic [31:0] tvec;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_write", 64'(pc_write), 64'd0);
    rst = 1'b0;
    #1;
    chk("boot_state", 64'(state), 64'd0);
    chk("boot_pc_write", 64'(pc_write), 64'd1);
    chk("boot_pc_sel", 64'(pc_sel), 64'd3);
    chk("boot_vec", 64'(vec_addr), 64'h28);

    // add: FETCH, DECODE, EXEC, WB
    tick(); chk("t1_fetch", 64'({state, ir_write}), 64'({3'd1, 1'b1}));
    tick(); chk("t1_decode", 64'(state), 64'd2);
    tick(); chk("t1_exec", 64'({state, alu_op, alu_src}), 64'({3'd3, 3'b010, 1'b0}));
    tick(); chk("t1_wb", 64'({state, reg_write, wb_sel}), 64'({3'd5, 1'b1, 2'b00}));
    tick(); chk("t1_retired", 64'(retired), 64'd1);

    run_instr(I_LW, 3, lat, n_mem, mr, mw, rw, tr, ex_psel, wbs, tvec);
    chk("lw_latency", 64'(lat), 64'd7);
    chk("lw_mem_read_cycles", 64'(mr), 64'd3);
    chk("lw_wb_sel", 64'(wbs), 64'd1);
    chk("lw_retired", 64'(retired), 64'd2);

    zero = 1'b1;
    run_instr(I_BEQ, 0, lat, n_mem, mr, mw, rw, tr, ex_psel, wbs, tvec);
    chk("beq_t_latency", 64'(lat), 64'd3);
    chk("beq_t_pc_sel", 64'(ex_psel), 64'd1);
    chk("beq_t_reg_write", 64'(rw), 64'd0);
    zero = 1'b0;
    run_instr(I_BEQ, 0, lat, n_mem, mr, mw, rw, tr, ex_psel, wbs, tvec);
    chk("beq_nt_latency", 64'(lat), 64'd3);
    chk("beq_nt_pc_sel", 64'(ex_psel), 64'd0);
    chk("beq_retired", 64'(retired), 64'd4);

    run_instr(I_SW, 0, lat, n_mem, mr, mw, rw, tr, ex_psel, wbs, tvec);
    chk("sw_tmo_mem_cycles", 64'(n_mem), 64'd15);
    chk("sw_tmo_latency", 64'(lat), 64'd19);
    chk("sw_tmo_trap", 64'(tr), 64'd1);
    chk("sw_tmo_vec", 64'(tvec), 64'(ENTRY));
    chk("sw_tmo_retired", 64'(retired), 64'd4);

    run_instr(I_SW, 1, lat, n_mem, mr, mw, rw, tr, ex_psel, wbs, tvec);
    chk("sw_fast_latency", 64'(lat), 64'd4);
    chk("sw_fast_mem_write", 64'(mw), 64'd1);
    run_instr(I_JAL, 0, lat, n_mem, mr, mw, rw, tr, ex_psel, wbs, tvec);
    chk("jal_latency", 64'(lat), 64'd4);
    chk("jal_wb_sel", 64'(wbs), 64'd2);
    run_instr(I_ADDI, 0, lat, n_mem, mr, mw, rw, tr, ex_psel, wbs, tvec);
    chk("addi_latency", 64'(lat), 64'd4);
    chk("misc_retired", 64'(retired), 64'd7);

    // interrupts only at FETCH
    ins = I_ADD; int_req = 1'b1; #1;
    chk("int1", 64'({state, pc_write, pc_sel, ir_write}), 64'({3'd1, 1'b1, 2'd3, 1'b0}));
    chk("int1_vec", 64'(vec_addr), 64'(ENTRY));
    tick();
    chk("int2", 64'({state, pc_write, pc_sel, ir_write}), 64'({3'd1, 1'b1, 2'd3, 1'b0}));
    tick(); int_req = 1'b0; #1;
    chk("int_resume", 64'({state, ir_write}), 64'({3'd1, 1'b1}));
    tick(); tick(); int_req = 1'b1; #1;
    chk("int_exec", 64'({state, pc_write, alu_op}), 64'({3'd3, 1'b0, 3'b010}));
    tick(); chk("int_wb", 64'(state), 64'd5);
    tick(); chk("int_next_fetch", 64'({state, pc_sel, ir_write}), 64'({3'd1, 2'd3, 1'b0}));
    int_req = 1'b0;
    chk("int_retired", 64'(retired), 64'd8);

    run_instr(I_BAD, 0, lat, n_mem, mr, mw, rw, tr, ex_psel, wbs, tvec);
    chk("bad_op_latency", 64'(lat), 64'd3);
    chk("bad_op_trap", 64'(tr), 64'd1);
    run_instr(I_RBAD, 0, lat, n_mem, mr, mw, rw, tr, ex_psel, wbs, tvec);
    chk("bad_f3_latency", 64'(lat), 64'd4);
    chk("trap_retired", 64'(retired), 64'd8);

    // reset in the middle of a load
    ins = I_LW;
    tick(); tick(); tick();
    chk("mid_mem_state", 64'({state, mem_read}), 64'({3'd4, 1'b1}));
    tick();
    rst = 1'b1; #1;
    chk("mid_mem_rst_strobes", 64'({mem_read, pc_write, reg_write}), 64'd0);
    tick(); rst = 1'b0; #1;
    chk("post_rst_boot", 64'({state, pc_write}), 64'({3'd0, 1'b1}));
    chk("post_rst_retired", 64'(retired), 64'd0);
    tick();

    repeat (7) run_instr(I_ADD, 0, lat, n_mem, mr, mw, rw, tr, ex_psel, wbs, tvec);
    chk("w3_before_wrap", 64'(s_retired), 64'd7);
    run_instr(I_ADD, 0, lat, n_mem, mr, mw, rw, tr, ex_psel, wbs, tvec);
    chk("w3_wrap", 64'(s_retired), 64'd0);
    chk("w32_no_wrap", 64'(retired), 64'd8);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
